cpu_mem_readback: RTL and testbench

Host-side reader for the coprocessor's CPU memory port. It is the mirror of the CPU write path used to load polynomials.
- On a start pulse it asserts cpu_interrupt, selects a memory block and a memory, and issues sequential reads over cpu_mem_addr.
- Read data, which returns with a fixed latency, is streamed out on a valid/ready coefficient stream with backpressure.
- Sits between homenc_coprocessor and the host DMA/bridge.

---
 rtl/cpu_mem_readback.sv | 209 ++++++++++++++++++++
 tb/tb_cpu_mem_readback.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_readback.sv
// Host-side readback of the coprocessor CPU memory port onto a valid/ready stream.
// Optional running checksum of streamed beats is enabled by defining READBACK_CHECKSUM_EN.

module cpu_mem_readback #(
  parameter int RD_LAT     = 2,
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 60,
  parameter int FIFO_DEPTH = RD_LAT + 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [2:0]        mb_sel,
  input  logic [3:0]        mem_sel,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              cpu_interrupt,
  output logic [2:0]        cpu_mb_sel,
  output logic [3:0]        cpu_mem_sel,
  output logic [ADDR_W-1:0] cpu_mem_addr,
  output logic              cpu_mem_wr_en,
  output logic [DATA_W-1:0] cpu_mem_wr_data,
  input  logic [DATA_W-1:0] cpu_mem_rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [DATA_W-1:0] checksum
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_W:0]  MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]  ONE      = (ADDR_W+1)'(1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_READ, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [2:0]        mb_q, mb_d;
  logic [3:0]        mem_q, mem_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   iss_cnt_q, iss_cnt_d;
  logic [ADDR_W:0]   out_cnt_q, out_cnt_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [RD_LAT-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W:0]    fill;
  logic [ADDR_W-1:0] rd_addr;
  logic              issue;
  logic              start_acc;
  logic              push;
  logic              hs;

  assign rd_addr = base_q + iss_cnt_q[ADDR_W-1:0];
  assign push    = sr_q[RD_LAT-1];
  assign m_valid = (occ_q != '0);
  assign m_data  = fifo_mem[rd_ptr_q];
  assign hs      = m_valid && m_ready;
  assign m_last  = m_valid && (out_cnt_q == (len_q - ONE));

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CNT_W'(sr_q[i]);
    end
    fill = {1'b0, occ_q} + {1'b0, inflight};
  end

  // Control FSM; a read is issued only when its returning word is guaranteed a FIFO slot
  always_comb begin
    state_d     = state_q;
    mb_d        = mb_q;
    mem_d       = mem_q;
    base_d      = base_q;
    len_d       = len_q;
    iss_cnt_d   = iss_cnt_q;
    out_cnt_d   = out_cnt_q;
    last_addr_d = last_addr_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    start_acc   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            start_acc = 1'b1;
            mb_d      = mb_sel;
            mem_d     = mem_sel;
            base_d    = base_addr;
            len_d     = (len > MAX_LEN) ? MAX_LEN : len;
            iss_cnt_d = '0;
            out_cnt_d = '0;
            state_d   = S_SETUP;
          end
        end
      end
      S_SETUP: state_d = S_READ;
      S_READ: begin
        if (fill < DEPTH_C) begin
          issue       = 1'b1;
          iss_cnt_d   = iss_cnt_q + ONE;
          last_addr_d = rd_addr;
          if (iss_cnt_d == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (hs && m_last) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (hs) out_cnt_d = out_cnt_q + ONE;
  end

  always_comb begin
    sr_d     = (sr_q << 1) | RD_LAT'(issue);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    if (hs)   rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({push, hs})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      mb_q        <= '0;
      mem_q       <= '0;
      base_q      <= '0;
      len_q       <= '0;
      iss_cnt_q   <= '0;
      out_cnt_q   <= '0;
      last_addr_q <= '0;
      sr_q        <= '0;
      occ_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mb_q        <= mb_d;
      mem_q       <= mem_d;
      base_q      <= base_d;
      len_q       <= len_d;
      iss_cnt_q   <= iss_cnt_d;
      out_cnt_q   <= out_cnt_d;
      last_addr_q <= last_addr_d;
      sr_q        <= sr_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= cpu_mem_rd_data;
  end

  // Address is driven in the issue cycle and otherwise parks on the last read address
  assign cpu_mem_addr    = issue ? rd_addr : last_addr_q;
  assign busy            = (state_q != S_IDLE);
  assign cpu_interrupt   = busy;
  assign done            = done_q;
  assign cpu_mb_sel      = mb_q;
  assign cpu_mem_sel     = mem_q;
  assign cpu_mem_wr_en   = 1'b0;
  assign cpu_mem_wr_data = '0;

`ifdef READBACK_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (start_acc)  checksum_d = '0;
    else if (hs)    checksum_d = checksum_q + m_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) checksum_q <= '0;
    else         checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_cpu_mem_readback.sv
// Directed bench for cpu_mem_readback: memory returns data[i]=i after a two-cycle read latency.
module tb_cpu_mem_readback;

  localparam int RD_LAT     = 2;
  localparam int ADDR_W     = 11;
  localparam int DATA_W     = 60;
  localparam int FIFO_DEPTH = RD_LAT + 2;

  logic              clk;
  logic              resetn;
  logic              start;
  logic [2:0]        mb_sel;
  logic [3:0]        mem_sel;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              cpu_interrupt;
  logic [2:0]        cpu_mb_sel;
  logic [3:0]        cpu_mem_sel;
  logic [ADDR_W-1:0] cpu_mem_addr;
  logic              cpu_mem_wr_en;
  logic [DATA_W-1:0] cpu_mem_wr_data;
  logic [DATA_W-1:0] cpu_mem_rd_data;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic [DATA_W-1:0] checksum;

  cpu_mem_readback #(
    .RD_LAT(RD_LAT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .mb_sel(mb_sel), .mem_sel(mem_sel),
    .base_addr(base_addr), .len(len), .busy(busy), .done(done),
    .cpu_interrupt(cpu_interrupt), .cpu_mb_sel(cpu_mb_sel), .cpu_mem_sel(cpu_mem_sel),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wr_en(cpu_mem_wr_en),
    .cpu_mem_wr_data(cpu_mem_wr_data), .cpu_mem_rd_data(cpu_mem_rd_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .checksum(checksum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: word i holds value i, returned two cycles after its address
  logic [ADDR_W-1:0] a1, a2;
  always @(posedge clk) begin
    a1 <= cpu_mem_addr;
    a2 <= a1;
  end
  assign cpu_mem_rd_data = DATA_W'(a2);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  bit mon_clr;
  int mon_base, mon_len;
  int beats, data_err, last_err, stab_err, occ_err, done_cnt, done_cyc, first_hs_cyc, last_hs_cyc;
  bit prev_stall;
  logic [DATA_W-1:0] prev_data;

  always @(negedge clk) begin
    if (mon_clr) begin
      beats <= 0; data_err <= 0; last_err <= 0; stab_err <= 0; occ_err <= 0;
      done_cnt <= 0; done_cyc <= -10; first_hs_cyc <= 0; last_hs_cyc <= 0;
      prev_stall <= 1'b0; prev_data <= '0;
    end else if (!resetn) begin
      prev_stall <= 1'b0;
    end else begin
      if (m_valid) begin
        if (m_last !== ((beats + 1) == mon_len)) last_err <= last_err + 1;
        if (m_ready) begin
          if (m_data !== DATA_W'((mon_base + beats) % 2048)) data_err <= data_err + 1;
          if (beats == 0) first_hs_cyc <= cyc;
          last_hs_cyc <= cyc;
          beats <= beats + 1;
        end
      end else if (m_last !== 1'b0) begin
        last_err <= last_err + 1;
      end
      if (prev_stall && (!m_valid || m_data !== prev_data)) stab_err <= stab_err + 1;
      prev_stall <= m_valid && !m_ready;
      prev_data  <= m_data;
      if (int'(dut.occ_q) > FIFO_DEPTH) occ_err <= occ_err + 1;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mon_reset(input int base, input int ln);
    mon_base = base;
    mon_len  = ln;
    mon_clr  = 1'b1;
    @(negedge clk);
    #1;
    mon_clr = 1'b0;
  endtask

  task automatic kick(input logic [2:0] mb, input logic [3:0] ms, input int base, input int ln);
    mb_sel    = mb;
    mem_sel   = ms;
    base_addr = ADDR_W'(base);
    len       = (ADDR_W+1)'(ln);
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc, input bit bp);
    bit got;
    got = 1'b0;
    for (int k = 0; k < maxc && !got; k++) begin
      m_ready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      step();
      if (done === 1'b1) got = 1'b1;
    end
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_irq_at_done"}, cpu_interrupt, 0);
    m_ready = 1'b1;
    step();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_done_after_last"}, done_cyc, last_hs_cyc + 1);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; mb_sel = '0; mem_sel = '0;
    base_addr = '0; len = '0; m_ready = 1'b0;
    mon_clr = 1'b1; mon_base = 0; mon_len = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_irq", cpu_interrupt, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_mb_sel", cpu_mb_sel, 0);
    chk("rst_mem_sel", cpu_mem_sel, 0);
    chk("rst_addr", cpu_mem_addr, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_wr_en", cpu_mem_wr_en, 0);
    chk("rst_wr_data", cpu_mem_wr_data, 0);
    mon_clr = 1'b0;
    resetn  = 1'b1;
    step();
    step();

    // Full memory read, ready always high
    mon_reset(0, 2048);
    m_ready = 1'b1;
    kick(3'd0, 4'd4, 0, 2048);
    chk("full_busy", busy, 1);
    chk("full_irq", cpu_interrupt, 1);
    chk("full_mem_sel", cpu_mem_sel, 4);
    chk("full_mb_sel", cpu_mb_sel, 0);
    wait_done("full", 2200, 1'b0);
    chk("full_beats", beats, 2048);
    chk("full_data_err", data_err, 0);
    chk("full_last_err", last_err, 0);
    chk("full_rate", last_hs_cyc - first_hs_cyc, 2047);
`ifdef READBACK_CHECKSUM_EN
    chk("full_checksum", checksum, 64'd2096128);
`else
    chk("full_checksum", checksum, 0);
`endif

    // Address wrap-around
    mon_reset(2046, 4);
    kick(3'd5, 4'd2, 2046, 4);
    chk("wrap_mb_sel", cpu_mb_sel, 5);
    chk("wrap_mem_sel", cpu_mem_sel, 2);
    wait_done("wrap", 100, 1'b0);
    chk("wrap_beats", beats, 4);
    chk("wrap_data_err", data_err, 0);
    chk("wrap_last_err", last_err, 0);

    // Backpressure 1-0-0-1
    mon_reset(0, 16);
    kick(3'd1, 4'd3, 0, 16);
    wait_done("bp", 300, 1'b1);
    chk("bp_beats", beats, 16);
    chk("bp_data_err", data_err, 0);
    chk("bp_stable_err", stab_err, 0);
    chk("bp_occ_err", occ_err, 0);
    chk("bp_last_err", last_err, 0);

    // len = 0: done next cycle, no reads
    chk("len0_addr_before", cpu_mem_addr, 15);
    mon_reset(0, 0);
    kick(3'd2, 4'd1, 0, 0);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_irq", cpu_interrupt, 0);
    step();
    chk("len0_done_pulse", done, 0);
    repeat (3) step();
    chk("len0_addr_after", cpu_mem_addr, 15);
    chk("len0_busy_after", busy, 0);
    chk("len0_done_count", done_cnt, 1);
    chk("len0_beats", beats, 0);

    // len above 2048 is clamped; a start while busy is ignored
    mon_reset(7, 2048);
    kick(3'd6, 4'd9, 7, 3000);
    repeat (5) step();
    kick(3'd7, 4'd15, 500, 5);
    chk("ign_mb_sel", cpu_mb_sel, 6);
    chk("ign_mem_sel", cpu_mem_sel, 9);
    chk("ign_busy", busy, 1);
    wait_done("clamp", 2300, 1'b0);
    chk("clamp_beats", beats, 2048);
    chk("clamp_data_err", data_err, 0);
    chk("clamp_last_err", last_err, 0);

    // Reset in the middle of a long read
    mon_reset(0, 2048);
    kick(3'd0, 4'd4, 0, 2048);
    for (int k = 0; k < 400 && beats < 100; k++) step();
    chk("mid_reached_100", (beats >= 100), 1);
    resetn = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_irq", cpu_interrupt, 0);
    chk("mid_m_valid", m_valid, 0);
    repeat (2) step();
    chk("mid_done_in_rst", done, 0);
    resetn = 1'b1;
    step();
    chk("mid_done_after", done, 0);
    chk("mid_busy_after", busy, 0);
    step();

    mon_reset(0, 8);
    kick(3'd0, 4'd4, 0, 8);
    wait_done("post_rst", 100, 1'b0);
    chk("post_rst_beats", beats, 8);
    chk("post_rst_data_err", data_err, 0);
    chk("post_rst_last_err", last_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
